ub_affine_read_sequencer: RTL and testbench

Read-side initiator for a 4-bank unified buffer. It walks a 3-level affine loop nest and drives `ren`, `ctrl_vars`, bank select and bank address into the buffer's banked storage. It captures the 1-cycle-latency bank read data and streams it out through a 2-entry valid/ready FIFO. It sits between a unified buffer's storage banks and the consuming compute op, and replaces hard-wired delay shift registers wherever the consumer can stall.

---
 rtl/ub_affine_read_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ub_affine_read_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_affine_read_sequencer.sv
`default_nettype none
// =============================================================================
// ub_affine_read_sequencer: walks a 3-level affine loop nest over a 4-bank
// unified buffer and streams read data through a 2-entry valid/ready FIFO.
// Rev 1.0
// =============================================================================
module ub_affine_read_sequencer #(
  parameter int DATA_W  = 16,
  parameter int CTRL_W  = 16,
  parameter int EXT0    = 1,
  parameter int EXT1    = 64,
  parameter int EXT2    = 64,
  parameter int STRIDE1 = 1,
  parameter int STRIDE2 = 64,
  parameter int BANK_AW = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   ren,
  output logic [2:0][CTRL_W-1:0] ctrl_vars,
  output logic [1:0]             bank_sel,
  output logic [BANK_AW-1:0]     bank_addr,
  input  logic [3:0][DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_RUN   = 2'd1;
  localparam logic [1:0] C_ST_DRAIN = 2'd2;

  localparam logic [CTRL_W-1:0] C_LAST0 = CTRL_W'(EXT0 - 1);
  localparam logic [CTRL_W-1:0] C_LAST1 = CTRL_W'(EXT1 - 1);
  localparam logic [CTRL_W-1:0] C_LAST2 = CTRL_W'(EXT2 - 1);

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic              w_pop;
  logic [2:0]        w_credit;
  logic              w_last;
  logic [DATA_W-1:0] w_rd_word;

  assign ctrl_vars[0] = cnt0_q;
  assign ctrl_vars[1] = cnt1_q;
  assign ctrl_vars[2] = cnt2_q;
  assign bank_sel     = {cnt2_q[0], cnt1_q[0]};
  // Only the low BANK_AW bits of the flat address survive; wrapping is intended.
  assign bank_addr    = BANK_AW'(cnt1_q) * BANK_AW'(STRIDE1)
                      + BANK_AW'(cnt2_q) * BANK_AW'(STRIDE2);

  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? (rd_ptr_q ? fifo1_q : fifo0_q) : '0;
  assign w_pop     = out_valid & out_ready;
  assign w_credit  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign ren       = (state_q == C_ST_RUN) && (w_credit < 3'd2);
  assign w_last    = ren && (cnt1_q == C_LAST1) && (cnt2_q == C_LAST2) && (cnt0_q == C_LAST0);
  assign busy      = (state_q != C_ST_IDLE);
  assign done      = (state_q == C_ST_DRAIN) && (count_q == 2'd0) && !inflight_q;
  assign w_rd_word = mem_rdata[sel_q];

  always_comb begin
    state_d    = state_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    inflight_d = ren;
    sel_d      = bank_sel;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, w_pop};

    // Read data returns one cycle after ren; a full FIFO may push and pop together.
    if (inflight_q) begin
      if (wr_ptr_q) fifo1_d = w_rd_word;
      else          fifo0_d = w_rd_word;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (w_pop) rd_ptr_d = ~rd_ptr_q;

    case (state_q)
      C_ST_IDLE: begin
        if (start) state_d = C_ST_RUN;
      end
      C_ST_RUN: begin
        if (ren) begin
          if (cnt1_q == C_LAST1) begin
            cnt1_d = '0;
            if (cnt2_q == C_LAST2) begin
              cnt2_d = '0;
              cnt0_d = (cnt0_q == C_LAST0) ? '0 : cnt0_q + CTRL_W'(1);
            end else begin
              cnt2_d = cnt2_q + CTRL_W'(1);
            end
          end else begin
            cnt1_d = cnt1_q + CTRL_W'(1);
          end
          if (w_last) state_d = C_ST_DRAIN;
        end
      end
      C_ST_DRAIN: begin
        if (done) state_d = C_ST_IDLE;
      end
      default: state_d = C_ST_IDLE;
    endcase

    if (flush) begin
      state_d    = C_ST_IDLE;
      cnt0_d     = '0;
      cnt1_d     = '0;
      cnt2_d     = '0;
      inflight_d = 1'b0;
      sel_d      = 2'd0;
      fifo0_d    = '0;
      fifo1_d    = '0;
      count_d    = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= C_ST_IDLE;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      inflight_q <= 1'b0;
      sel_q      <= 2'd0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      inflight_q <= inflight_d;
      sel_q      <= sel_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ub_affine_read_sequencer.sv
`default_nettype none
// =============================================================================
// tb_ub_affine_read_sequencer: scoreboard bench with a loop-nest reference model.
// Rev 1.0
// =============================================================================
module tb_ub_affine_read_sequencer;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 12;
  localparam int E0 = 1;
  localparam int E1 = 4;
  localparam int E2 = 3;
  localparam int S1 = 1;
  localparam int S2 = 64;
  localparam int N  = E0 * E1 * E2;

  typedef struct packed {
    logic [CW-1:0] c2;
    logic [CW-1:0] c1;
    logic [CW-1:0] c0;
    logic [1:0]    sel;
    logic [AW-1:0] addr;
  } iss_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, flush = 1'b0;
  logic start = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic out_ready = 1'b1, out_ready2 = 1'b1, out_ready3 = 1'b1;

  logic busy, done, ren, out_valid;
  logic [2:0][CW-1:0] ctrl_vars;
  logic [1:0] bank_sel;
  logic [AW-1:0] bank_addr;
  logic [3:0][DW-1:0] mem_rdata;
  logic [DW-1:0] out_data;

  logic busy2, done2, ren2, out_valid2;
  logic [2:0][CW-1:0] ctrl_vars2;
  logic [1:0] bank_sel2;
  logic [AW-1:0] bank_addr2;
  logic [3:0][DW-1:0] mem_rdata2;
  logic [DW-1:0] out_data2;

  logic busy3, done3, ren3, out_valid3;
  logic [2:0][CW-1:0] ctrl_vars3;
  logic [1:0] bank_sel3;
  logic [AW-1:0] bank_addr3;
  logic [3:0][DW-1:0] mem_rdata3;
  logic [DW-1:0] out_data3;

  ub_affine_read_sequencer #(.DATA_W(DW), .CTRL_W(CW), .EXT0(E0), .EXT1(E1), .EXT2(E2),
    .STRIDE1(S1), .STRIDE2(S2), .BANK_AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .busy(busy), .done(done),
    .ren(ren), .ctrl_vars(ctrl_vars), .bank_sel(bank_sel), .bank_addr(bank_addr),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

  ub_affine_read_sequencer #(.DATA_W(DW), .CTRL_W(CW), .EXT0(1), .EXT1(2), .EXT2(5),
    .STRIDE1(1), .STRIDE2(1024), .BANK_AW(AW)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start2), .busy(busy2), .done(done2),
    .ren(ren2), .ctrl_vars(ctrl_vars2), .bank_sel(bank_sel2), .bank_addr(bank_addr2),
    .mem_rdata(mem_rdata2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2));

  ub_affine_read_sequencer #(.DATA_W(DW), .CTRL_W(CW), .EXT0(1), .EXT1(1), .EXT2(1),
    .STRIDE1(1), .STRIDE2(64), .BANK_AW(AW)) u_dut_one (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start3), .busy(busy3), .done(done3),
    .ren(ren3), .ctrl_vars(ctrl_vars3), .bank_sel(bank_sel3), .bank_addr(bank_addr3),
    .mem_rdata(mem_rdata3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3));

  // Memory model: every bank returns bank*4096 + address, one cycle after ren.
  function automatic logic [3:0][DW-1:0] bank_words(input logic [AW-1:0] a);
    for (int b = 0; b < 4; b++) bank_words[b] = DW'(b * 4096 + int'(a));
  endfunction

  logic [AW-1:0] raddr = '0, raddr2 = '0, raddr3 = '0;
  always @(posedge clk) begin
    if (ren)  raddr  <= bank_addr;
    if (ren2) raddr2 <= bank_addr2;
    if (ren3) raddr3 <= bank_addr3;
  end
  assign mem_rdata  = bank_words(raddr);
  assign mem_rdata2 = bank_words(raddr2);
  assign mem_rdata3 = bank_words(raddr3);

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iss_t exp_iss[$];
  logic [DW-1:0] exp_out[$];
  int out_cyc[$];
  int n_iss = 0, n_done = 0, done_cyc = 0;
  iss_t mon_e;
  logic [DW-1:0] mon_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: enumerate the loop nest element by element with plain arithmetic.
  task automatic push_sweep();
    for (int i = 0; i < N; i++) begin
      int c1, c2, c0, flat, bank;
      iss_t e;
      c1   = i % E1;
      c2   = (i / E1) % E2;
      c0   = i / (E1 * E2);
      flat = c1 * S1 + c2 * S2;
      bank = (c1 % 2) + 2 * (c2 % 2);
      e.c0 = CW'(c0); e.c1 = CW'(c1); e.c2 = CW'(c2);
      e.sel = 2'(bank); e.addr = AW'(flat % 4096);
      exp_iss.push_back(e);
      exp_out.push_back(DW'(bank * 4096 + flat % 4096));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ren) begin
        n_iss++;
        if (exp_iss.size() == 0) begin
          tests++; fails++;
          $display("FAIL issue_unexpected: got ren=1 with ctrl_vars=%0h expected no issue", ctrl_vars);
        end else begin
          mon_e = exp_iss.pop_front();
          chk("ctrl_vars", ctrl_vars, {mon_e.c2, mon_e.c1, mon_e.c0});
          chk("bank_sel", bank_sel, mon_e.sel);
          chk("bank_addr", bank_addr, mon_e.addr);
        end
      end
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (exp_out.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_unexpected: got out_data=%0d expected no output", out_data);
        end else begin
          mon_d = exp_out.pop_front();
          chk("out_data", out_data, mon_d);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit rnd);
    int d0, k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = rnd && busy && ($urandom_range(0, 7) == 0);
      tick();
      k++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (n_done == d0) begin
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
    end
    tick(); tick();
    chk("done_once", n_done - d0, 1);
    chk("idle_after_done", busy, 0);
    chk("iss_left", exp_iss.size(), 0);
    chk("out_left", exp_out.size(), 0);
  endtask

  initial begin
    int t0, k, stall_ren, iss_base;

    // Reset state
    tick(); tick();
    chk("reset_outs", |{busy, done, ren, ctrl_vars, bank_sel, bank_addr, out_data, out_valid}, 0);
    rst_n = 1'b1;
    tick();

    // Full rate, out_ready held high
    out_cyc.delete();
    push_sweep();
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc;
    chk("busy_first", busy, 1);
    chk("ren_first", ren, 1);
    wait_done(0);
    chk("full_n_out", out_cyc.size(), N);
    if (out_cyc.size() == N) begin
      chk("full_first_out_cyc", out_cyc[0], t0 + 2);
      chk("full_last_out_cyc", out_cyc[N-1], t0 + N + 1);
    end
    chk("full_done_cyc", done_cyc, t0 + N + 2);

    // Backpressure: 5 stalled cycles from the first out_valid
    out_cyc.delete();
    push_sweep();
    iss_base = n_iss;
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin tick(); k++; end
    chk("bp_first_valid_lat", k, 2);
    out_ready = 1'b0;
    stall_ren = 0;
    for (int s = 0; s < 5; s++) begin
      #1;
      stall_ren += int'(ren);
      tick();
    end
    chk("bp_ren_during_stall", stall_ren, 0);
    chk("bp_issued_before_release", n_iss - iss_base, 2);
    chk("bp_valid_held", out_valid, 1);
    wait_done(0);
    chk("bp_n_out", out_cyc.size(), N);
    if (out_cyc.size() == N) chk("bp_no_gaps", out_cyc[N-1] - out_cyc[0], N - 1);

    // Flush on the cycle element 5 is issued, then a clean replay
    push_sweep();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("flush_ren_e5", ren, 1);
    chk("flush_ctrl_e5", ctrl_vars, {16'd1, 16'd1, 16'd0});
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ren", ren, 0);
    exp_iss.delete();
    exp_out.delete();
    repeat (3) tick();
    push_sweep();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(0);

    // Random backpressure with stray start pulses during the sweep
    for (int r = 0; r < 4; r++) begin
      push_sweep();
      start = 1'b1; tick(); start = 1'b0;
      wait_done(1);
    end

    // Async reset while draining
    push_sweep();
    start = 1'b1; tick(); start = 1'b0;
    repeat (N) tick();
    chk("drain_state", {busy, ren}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", |{busy, done, ren, ctrl_vars, bank_sel, bank_addr, out_data, out_valid}, 0);
    exp_iss.delete();
    exp_out.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Address wrap: STRIDE2=1024, EXT1=2, EXT2=5
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (8) tick();
    chk("wrap_ren", ren2, 1);
    chk("wrap_ctrl", {ctrl_vars2[2], ctrl_vars2[1]}, {16'd4, 16'd0});
    chk("wrap_addr0", bank_addr2, 0);
    chk("wrap_sel0", bank_sel2, 0);
    tick();
    chk("wrap_addr1", bank_addr2, 1);
    chk("wrap_sel1", bank_sel2, 1);
    tick();
    chk("wrap_out8", {out_valid2, out_data2}, {1'b1, 16'd0});
    tick();
    chk("wrap_out9", {out_valid2, out_data2}, {1'b1, 16'd4097});
    repeat (4) tick();
    chk("wrap_idle", busy2, 0);

    // Extents 1x1x1
    start3 = 1'b1; tick(); start3 = 1'b0;
    chk("one_ren", {busy3, ren3}, 2'b11);
    tick();
    chk("one_no_valid_early", out_valid3, 0);
    tick();
    chk("one_out", {out_valid3, out_data3}, {1'b1, 16'd0});
    tick();
    chk("one_done", done3, 1);
    tick();
    chk("one_idle", {busy3, done3}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
